// File: rtl/ecc_err_log.sv
// ecc_err_log -- error-event logger placed after the ECC decoder.
//
// Counts single-bit, repaired and double-bit decode events in saturating
// counters. Captures the address and syndrome of the first event, and a later
// double-bit event replaces a single-bit capture. Raises a level interrupt.
// With ECC_ERR_LOG_FIFO_EN defined, an address FIFO also records every event.
// Without it, the FIFO outputs are tied to their empty values.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clkena_i, valid_i   an event is accepted only when both are high
//   addr_i, syndrome_i  address and syndrome of the decoded word
//   sb_err_i, db_err_i  single-bit and double-bit flags; double-bit wins
//   sb_fix_i            single-bit error repaired in the information bits
//   thr_i               single-bit interrupt threshold; 0 disables it
//   clr_i               synchronous clear; an event in the same cycle is still logged
//   sb_cnt_o, fix_cnt_o, db_cnt_o       saturating event counters
//   cap_valid_o, cap_db_o, cap_addr_o, cap_syn_o   capture registers
//   irq_o               capture is double-bit, or sb count >= threshold
//   fifo_rd_i, fifo_addr_o, fifo_empty_o, fifo_ovf_o   error-address FIFO
module ecc_err_log #(
  parameter int unsigned AW         = 32,
  parameter int unsigned M          = 7,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clkena_i,
  input  logic             valid_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [M-1:0]     syndrome_i,
  input  logic             sb_err_i,
  input  logic             db_err_i,
  input  logic             sb_fix_i,
  input  logic [CNT_W-1:0] thr_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] fix_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic             cap_valid_o,
  output logic             cap_db_o,
  output logic [AW-1:0]    cap_addr_o,
  output logic [M-1:0]     cap_syn_o,
  output logic             irq_o,
  input  logic             fifo_rd_i,
  output logic [AW-1:0]    fifo_addr_o,
  output logic             fifo_empty_o,
  output logic             fifo_ovf_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAP_SB = 2'd1,
    CAP_DB = 2'd2
  } state_t;

  // Event qualification; a double-bit flag overrides the single-bit flags.
  logic accept;
  logic db_ev;
  logic sb_ev;
  logic fix_ev;

  assign accept = clkena_i & valid_i;
  assign db_ev  = accept & db_err_i;
  assign sb_ev  = accept & sb_err_i & ~db_err_i;
  assign fix_ev = sb_ev & sb_fix_i;

  // Clear-then-increment with saturation at all-ones.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic             clr,
                                                 input logic             inc);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != '1)) begin
      base = base + CNT_W'(1);
    end
    return base;
  endfunction

  logic [CNT_W-1:0] sb_cnt;
  logic [CNT_W-1:0] fix_cnt;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] sb_cnt_nxt;
  logic [CNT_W-1:0] fix_cnt_nxt;
  logic [CNT_W-1:0] db_cnt_nxt;

  always_comb begin
    sb_cnt_nxt  = cnt_next(sb_cnt, clr_i, sb_ev);
    fix_cnt_nxt = cnt_next(fix_cnt, clr_i, fix_ev);
    db_cnt_nxt  = cnt_next(db_cnt, clr_i, db_ev);
  end

  // Event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_cnt  <= '0;
      fix_cnt <= '0;
      db_cnt  <= '0;
    end else begin
      sb_cnt  <= sb_cnt_nxt;
      fix_cnt <= fix_cnt_nxt;
      db_cnt  <= db_cnt_nxt;
    end
  end

  // Clear collapses the state to IDLE before the current event is applied.
  state_t state;
  state_t state_base;

  always_comb begin
    state_base = clr_i ? IDLE : state;
  end

  // Capture FSM: first event is captured, a double-bit event upgrades a
  // single-bit capture, and a double-bit capture holds until cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cap_addr_o <= '0;
      cap_syn_o  <= '0;
    end else begin
      if (clr_i) begin
        state      <= IDLE;
        cap_addr_o <= '0;
        cap_syn_o  <= '0;
      end
      case (state_base)
        IDLE: begin
          if (db_ev) begin
            state      <= CAP_DB;
            cap_addr_o <= addr_i;
            cap_syn_o  <= syndrome_i;
          end else if (sb_ev) begin
            state      <= CAP_SB;
            cap_addr_o <= addr_i;
            cap_syn_o  <= syndrome_i;
          end
        end
        CAP_SB: begin
          if (db_ev) begin
            state      <= CAP_DB;
            cap_addr_o <= addr_i;
            cap_syn_o  <= syndrome_i;
          end
        end
        CAP_DB: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sb_cnt_o    = sb_cnt;
  assign fix_cnt_o   = fix_cnt;
  assign db_cnt_o    = db_cnt;
  assign cap_valid_o = (state != IDLE);
  assign cap_db_o    = (state == CAP_DB);

  // Threshold compare is the only combinational path from an input to irq_o.
  assign irq_o = (state == CAP_DB) | ((thr_i != '0) & (sb_cnt >= thr_i));

`ifdef ECC_ERR_LOG_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_F = PTR_W + 1;

  logic [AW-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_F-1:0] count;
  logic             full;
  logic             push;
  logic             pop;
  logic             push_ok;

  assign full    = (count == CNT_F'(FIFO_DEPTH));
  assign push    = db_ev | sb_ev;
  assign pop     = fifo_rd_i & (count != '0) & ~clr_i;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push & (~full | pop);

  // Address FIFO; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_ovf_o <= 1'b0;
    end else if (clr_i) begin
      rd_ptr     <= '0;
      fifo_ovf_o <= 1'b0;
      if (push) begin
        mem[0] <= addr_i;
        wr_ptr <= PTR_W'(1);
        count  <= CNT_F'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        mem[wr_ptr] <= addr_i;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (push && !push_ok) begin
        fifo_ovf_o <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_F'(1);
        2'b01:   count <= count - CNT_F'(1);
        default: count <= count;
      endcase
    end
  end

  assign fifo_addr_o  = mem[rd_ptr];
  assign fifo_empty_o = (count == '0);
`else
  localparam int unsigned fifo_depth_unused = FIFO_DEPTH;
  logic unused_fifo_rd;

  assign unused_fifo_rd = fifo_rd_i;
  assign fifo_addr_o    = '0;
  assign fifo_empty_o   = 1'b1;
  assign fifo_ovf_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_err_log.sv
// Self-checking bench for ecc_err_log. A behavioural model (saturating ints,
// a severity level for the capture, a queue for the FIFO) predicts every output.
module tb_ecc_err_log;

  localparam int unsigned AW    = 32;
  localparam int unsigned M     = 7;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clkena;
  logic             valid;
  logic [AW-1:0]    addr;
  logic [M-1:0]     syn;
  logic             sb;
  logic             db;
  logic             fix;
  logic [CNT_W-1:0] thr;
  logic             clr;
  logic             fifo_rd;
  logic [CNT_W-1:0] sb_cnt;
  logic [CNT_W-1:0] fix_cnt;
  logic [CNT_W-1:0] db_cnt;
  logic             cap_valid;
  logic             cap_db;
  logic [AW-1:0]    cap_addr;
  logic [M-1:0]     cap_syn;
  logic             irq;
  logic [AW-1:0]    fifo_addr;
  logic             fifo_empty;
  logic             fifo_ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int              m_sb, m_fix, m_db;
  int              m_lvl;   // 0 none, 1 single-bit, 2 double-bit
  logic [AW-1:0]   m_addr;
  logic [M-1:0]    m_syn;
  logic [AW-1:0]   m_q[$];
  bit              m_ovf;

  ecc_err_log #(.AW(AW), .M(M), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .valid_i(valid),
    .addr_i(addr), .syndrome_i(syn), .sb_err_i(sb), .db_err_i(db),
    .sb_fix_i(fix), .thr_i(thr), .clr_i(clr),
    .sb_cnt_o(sb_cnt), .fix_cnt_o(fix_cnt), .db_cnt_o(db_cnt),
    .cap_valid_o(cap_valid), .cap_db_o(cap_db), .cap_addr_o(cap_addr),
    .cap_syn_o(cap_syn), .irq_o(irq), .fifo_rd_i(fifo_rd),
    .fifo_addr_o(fifo_addr), .fifo_empty_o(fifo_empty), .fifo_ovf_o(fifo_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sb = 0; m_fix = 0; m_db = 0; m_lvl = 0;
    m_addr = '0; m_syn = '0; m_q.delete(); m_ovf = 0;
  endtask

  // Apply the logging rules to the inputs present at the coming edge.
  task automatic model_step();
    bit acc, is_db, is_sb;
    if (clr) begin
      m_sb = 0; m_fix = 0; m_db = 0; m_lvl = 0;
      m_addr = '0; m_syn = '0; m_q.delete(); m_ovf = 0;
    end
    acc   = clkena && valid;
    is_db = acc && db;
    is_sb = acc && sb && !db;
`ifdef ECC_ERR_LOG_FIFO_EN
    if (fifo_rd && m_q.size() > 0) void'(m_q.pop_front());
    if (is_db || is_sb) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(addr);
      else m_ovf = 1;
    end
`endif
    if (is_db) m_db = (m_db < MAXC) ? m_db + 1 : MAXC;
    if (is_sb) m_sb = (m_sb < MAXC) ? m_sb + 1 : MAXC;
    if (is_sb && fix) m_fix = (m_fix < MAXC) ? m_fix + 1 : MAXC;
    if ((is_db && m_lvl < 2) || (is_sb && m_lvl == 0)) begin
      m_lvl  = is_db ? 2 : 1;
      m_addr = addr;
      m_syn  = syn;
    end
  endtask

  function automatic bit model_irq();
    return (m_lvl == 2) || (thr != 0 && m_sb >= int'(thr));
  endfunction

  task automatic cycle();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clkena = 1'b1; valid = 1'b0; sb = 1'b0; db = 1'b0; fix = 1'b0;
    clr = 1'b0; fifo_rd = 1'b0; addr = '0; syn = '0;
  endtask

  task automatic event_cycle(input bit is_db, input bit is_sb, input bit is_fix,
                             input logic [AW-1:0] a, input logic [M-1:0] s);
    valid = 1'b1; db = is_db; sb = is_sb; fix = is_fix; addr = a; syn = s;
    cycle();
    idle_inputs();
  endtask

  task automatic do_clear();
    clr = 1'b1; clkena = 1'b0;
    cycle();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; thr = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({sb_cnt, fix_cnt, db_cnt} !== '0) begin
      n_errors++; $display("FAIL reset_counters: got %0h required 0", {sb_cnt, fix_cnt, db_cnt});
    end
    n_checks++;
    if ({cap_valid, cap_db, irq, fifo_ovf, fifo_empty} !== 5'b00001) begin
      n_errors++; $display("FAIL reset_flags: got %b required 00001", {cap_valid, cap_db, irq, fifo_ovf, fifo_empty});
    end
    n_checks++;
    if ({cap_addr, cap_syn} !== '0) begin
      n_errors++; $display("FAIL reset_capture: got %0h required 0", {cap_addr, cap_syn});
    end
  endtask

  task automatic test_clean_stream();
    for (int i = 0; i < 100; i++) begin
      valid = 1'b1; addr = $urandom; syn = M'($urandom);
      cycle();
    end
    idle_inputs();
    n_checks++;
    if ({sb_cnt, fix_cnt, db_cnt, cap_valid, irq} !== '0) begin
      n_errors++; $display("FAIL clean_stream: got %0h required 0", {sb_cnt, fix_cnt, db_cnt, cap_valid, irq});
    end
  endtask

  task automatic test_sb_then_db();
    event_cycle(0, 1, 0, 32'h10, 7'h05);
    n_checks++;
    if ({cap_valid, cap_db, cap_addr, cap_syn} !== {1'b1, 1'b0, 32'h10, 7'h05}) begin
      n_errors++; $display("FAIL sb_capture: got v=%b db=%b a=%0h s=%0h required 1 0 10 05", cap_valid, cap_db, cap_addr, cap_syn);
    end
    event_cycle(1, 0, 0, 32'h20, 7'h40);
    n_checks++;
    if ({sb_cnt, db_cnt, cap_db, cap_addr, cap_syn, irq} !== {4'd1, 4'd1, 1'b1, 32'h20, 7'h40, 1'b1}) begin
      n_errors++; $display("FAIL db_upgrade: got sb=%0d db=%0d cdb=%b a=%0h s=%0h irq=%b required 1 1 1 20 40 1",
                           sb_cnt, db_cnt, cap_db, cap_addr, cap_syn, irq);
    end
    event_cycle(0, 1, 1, 32'h30, 7'h11);
    n_checks++;
    if ({sb_cnt, fix_cnt, cap_db, cap_addr, cap_syn} !== {4'd2, 4'd1, 1'b1, 32'h20, 7'h40}) begin
      n_errors++; $display("FAIL db_hold: got sb=%0d fix=%0d cdb=%b a=%0h s=%0h required 2 1 1 20 40",
                           sb_cnt, fix_cnt, cap_db, cap_addr, cap_syn);
    end
  endtask

  task automatic test_threshold();
    do_clear();
    n_checks++;
    if ({sb_cnt, db_cnt, cap_valid, irq} !== '0) begin
      n_errors++; $display("FAIL clear_no_clkena: got %0h required 0", {sb_cnt, db_cnt, cap_valid, irq});
    end
    thr = 4'd3;
    for (int i = 0; i < 3; i++) begin
      event_cycle(0, 1, 1, AW'(32'h100 + i), M'(i + 1));
      n_checks++;
      if (irq !== (i == 2)) begin
        n_errors++; $display("FAIL thr_irq_%0d: got %b required %b", i, irq, (i == 2));
      end
    end
    n_checks++;
    if ({fix_cnt, sb_cnt, cap_db} !== {4'd3, 4'd3, 1'b0}) begin
      n_errors++; $display("FAIL thr_counts: got fix=%0d sb=%0d cdb=%b required 3 3 0", fix_cnt, sb_cnt, cap_db);
    end
    thr = '0;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++; $display("FAIL thr_disable_comb: got %b required 0", irq);
    end
  endtask

  task automatic test_saturation_gating();
    do_clear();
    for (int i = 0; i < 20; i++) event_cycle(1, 0, 0, $urandom, M'($urandom));
    n_checks++;
    if (db_cnt !== 4'd15) begin
      n_errors++; $display("FAIL db_saturate: got %0d required 15", db_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      clkena = (i < 3) ? 1'b0 : 1'b1;
      valid  = (i < 3) ? 1'b1 : 1'b0;
      sb = 1'b1; db = (i == 1); fix = 1'b1; addr = $urandom;
      cycle();
    end
    idle_inputs();
    n_checks++;
    if ({sb_cnt, fix_cnt, db_cnt} !== {4'd0, 4'd0, 4'd15}) begin
      n_errors++; $display("FAIL gating: got sb=%0d fix=%0d db=%0d required 0 0 15", sb_cnt, fix_cnt, db_cnt);
    end
  endtask

  task automatic test_clear_collision();
    clr = 1'b1;
    event_cycle(0, 1, 0, 32'hABC, 7'h11);
    n_checks++;
    if ({sb_cnt, db_cnt, cap_valid, cap_db, cap_addr, cap_syn} !== {4'd1, 4'd0, 1'b1, 1'b0, 32'hABC, 7'h11}) begin
      n_errors++; $display("FAIL clear_collision: got sb=%0d db=%0d v=%b cdb=%b a=%0h s=%0h required 1 0 1 0 abc 11",
                           sb_cnt, db_cnt, cap_valid, cap_db, cap_addr, cap_syn);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clkena  = ($urandom_range(0, 7) != 0);
      valid   = ($urandom_range(0, 3) != 0);
      sb      = ($urandom_range(0, 2) == 0);
      db      = ($urandom_range(0, 9) == 0);
      fix     = $urandom_range(0, 1);
      clr     = ($urandom_range(0, 39) == 0);
      fifo_rd = ($urandom_range(0, 2) == 0);
      addr    = $urandom;
      syn     = M'($urandom);
      if ($urandom_range(0, 19) == 0) thr = CNT_W'($urandom_range(0, 6));
      cycle();
      n_checks++;
      if (sb_cnt !== CNT_W'(m_sb) || fix_cnt !== CNT_W'(m_fix) || db_cnt !== CNT_W'(m_db)) begin
        n_errors++; $display("FAIL rand_counters[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                             i, sb_cnt, fix_cnt, db_cnt, m_sb, m_fix, m_db);
      end
      n_checks++;
      if (cap_valid !== (m_lvl != 0) || cap_db !== (m_lvl == 2) || irq !== model_irq() ||
          (m_lvl != 0 && (cap_addr !== m_addr || cap_syn !== m_syn))) begin
        n_errors++; $display("FAIL rand_capture[%0d]: got v=%b db=%b irq=%b a=%0h s=%0h required lvl=%0d irq=%b a=%0h s=%0h",
                             i, cap_valid, cap_db, irq, cap_addr, cap_syn, m_lvl, model_irq(), m_addr, m_syn);
      end
      n_checks++;
      if (fifo_empty !== (m_q.size() == 0) || fifo_ovf !== m_ovf ||
          (m_q.size() != 0 && fifo_addr !== m_q[0]) || (m_q.size() == 0 && fifo_empty !== 1'b1)) begin
        n_errors++; $display("FAIL rand_fifo[%0d]: got e=%b o=%b a=%0h required size=%0d o=%b",
                             i, fifo_empty, fifo_ovf, fifo_addr, m_q.size(), m_ovf);
      end
    end
    idle_inputs();
  endtask

`ifdef ECC_ERR_LOG_FIFO_EN
  task automatic test_fifo();
    logic [AW-1:0] exp_a;
    do_clear();
    for (int i = 0; i < 5; i++) event_cycle(i % 2, 1, 0, AW'(32'h1000 + 16 * i), 7'h01);
    n_checks++;
    if ({fifo_empty, fifo_ovf} !== 2'b01) begin
      n_errors++; $display("FAIL fifo_overflow: got empty=%b ovf=%b required 0 1", fifo_empty, fifo_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      exp_a = AW'(32'h1000 + 16 * i);
      n_checks++;
      if (fifo_empty !== 1'b0 || fifo_addr !== exp_a) begin
        n_errors++; $display("FAIL fifo_pop_%0d: got e=%b a=%0h required 0 %0h", i, fifo_empty, fifo_addr, exp_a);
      end
      fifo_rd = 1'b1;
      cycle();
    end
    fifo_rd = 1'b1;
    cycle();
    idle_inputs();
    n_checks++;
    if ({fifo_empty, fifo_ovf} !== 2'b11) begin
      n_errors++; $display("FAIL fifo_drained: got empty=%b ovf=%b required 1 1", fifo_empty, fifo_ovf);
    end
  endtask
`else
  task automatic test_fifo();
    fifo_rd = 1'b1;
    event_cycle(1, 0, 0, 32'h55, 7'h02);
    n_checks++;
    if ({fifo_empty, fifo_ovf, fifo_addr} !== {1'b1, 1'b0, 32'h0}) begin
      n_errors++; $display("FAIL fifo_disabled: got e=%b o=%b a=%0h required 1 0 0", fifo_empty, fifo_ovf, fifo_addr);
    end
  endtask
`endif

  task automatic test_async_reset();
    thr = 4'd1;
    event_cycle(1, 0, 0, 32'h77, 7'h22);
    event_cycle(0, 1, 1, 32'h78, 7'h23);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({sb_cnt, fix_cnt, db_cnt, cap_valid, cap_db, cap_addr, cap_syn, irq, fifo_ovf} !== '0 || fifo_empty !== 1'b1) begin
      n_errors++; $display("FAIL async_reset: got sb=%0d db=%0d v=%b irq=%b e=%b required all clear",
                           sb_cnt, db_cnt, cap_valid, irq, fifo_empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    thr = '0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_clean_stream();
    test_sb_then_db();
    test_threshold();
    test_saturation_gating();
    test_clear_collision();
    test_fifo();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ecc_err_log.md
# ecc_err_log

Error-event logger that sits directly downstream of `ecc_dec` and consumes its flag and syndrome outputs. It counts single-bit, corrected and double-bit events with saturating counters and captures the address and syndrome of the first, or most severe, error. It raises a level interrupt toward the system. Memory controllers and scrubbers use it to decide when to scrub or retire a region.

## Interface
- `AW`, 32, width of the address that accompanies each decoded word
- `M`, 7, syndrome width; equals the decoder's m (7 for K=64)
- `CNT_W`, 16, width of each event counter
- `FIFO_DEPTH`, 4, error-address FIFO entries; power of two, ≥2; used only when the FIFO feature is compiled in

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; asynchronous, active-low
- `clkena_i`  in  1  clock enable; same signal that drives the decoder
- `valid_i`  in  1  decoder output word valid this cycle
- `addr_i`  in  AW  address of the decoded word
- `syndrome_i`  in  M  decoder syndrome
- `sb_err_i`  in  1  single-bit error detected
- `db_err_i`  in  1  double-bit error detected
- `sb_fix_i`  in  1  single-bit error repaired in information bits
- `thr_i`  in  CNT_W  single-bit interrupt threshold; 0 disables
- `clr_i`  in  1  synchronous clear of all logged state
- `sb_cnt_o`  out  CNT_W  single-bit event count
- `fix_cnt_o`  out  CNT_W  repaired-bit event count
- `db_cnt_o`  out  CNT_W  double-bit event count
- `cap_valid_o`  out  1  capture registers hold an event
- `cap_db_o`  out  1  captured event is double-bit
- `cap_addr_o`  out  AW  captured address
- `cap_syn_o`  out  M  captured syndrome
- `irq_o`  out  1  level interrupt
- `fifo_rd_i`  in  1  pop error-address FIFO
- `fifo_addr_o`  out  AW  FIFO head address
- `fifo_empty_o`  out  1  FIFO empty
- `fifo_ovf_o`  out  1  sticky, set when an event is dropped because the FIFO is full

## Operation
- **Reset values.**
  - All counters, `cap_*_o`, `irq_o` and `fifo_ovf_o` are 0.
  - `fifo_empty_o` is 1.
  - The FSM is in IDLE.
- **Accepted event.** Sampled when `clkena_i & valid_i`.
  - DB event: `db_err_i` is set. A DB event overrides `sb_err_i` and `sb_fix_i`; when `db_err_i`=1, only `db_cnt` increments.
  - SB event: `sb_err_i & ~db_err_i`. `fix_cnt` additionally increments when `sb_fix_i` is set.
  - Flags present without `valid_i`, or while `clkena_i`=0, are ignored.
- **Counters.** Increment by 1 and saturate at 2^CNT_W−1; they never wrap.
- **Capture FSM.**
  - IDLE: SB event → CAP_SB, DB event → CAP_DB. Both transitions load the address and syndrome.
  - CAP_SB: DB event → CAP_DB, reloading address and syndrome. Further SB events are ignored.
  - CAP_DB: holds until `clr_i`.
  - `cap_valid_o` = (state≠IDLE); `cap_db_o` = (state==CAP_DB).
- **Interrupt.** `irq_o` = CAP_DB | (`thr_i`≠0 & `sb_cnt` ≥ `thr_i`), computed from registered state.
  - Changing `thr_i` affects `irq_o` combinationally in the same cycle.
- **Clear.**
  - `clr_i` zeroes the counters, returns the FSM to IDLE, empties the FIFO and clears `fifo_ovf_o`.
  - It does not require `clkena_i`.
  - If an event is accepted in the same cycle, the clear applies first and that event is then logged: counter becomes 1 and the FSM loads it.
- **Reset mid-operation.** All state returns to reset values immediately. No event is lost partially: there are no multi-cycle operations.

## Timing
- Latency is 1 cycle: an event accepted at edge N is visible on the counters, capture outputs and `irq_o` after edge N.
- `irq_o` is driven from registers, except for the `thr_i` compare path.
- FIFO behaviour:
  - Push occurs at the same edge as the event is accepted.
  - `fifo_addr_o` shows the head entry combinationally from storage.
  - A pop on `fifo_rd_i` while empty is ignored.
  - Simultaneous push and pop while full: the pop frees the entry, the push succeeds, and no overflow is recorded.

## Configuration
- `ECC_ERR_LOG_FIFO_EN` defined: a FIFO of depth FIFO_DEPTH records `addr_i` for every accepted SB or DB event.
  - A push while full (and not popped) drops the address and sets `fifo_ovf_o`.
- `ECC_ERR_LOG_FIFO_EN` undefined: no storage is built.
  - `fifo_addr_o` is 0, `fifo_empty_o` is 1 and `fifo_ovf_o` is 0.
  - `fifo_rd_i` is ignored.
  - `FIFO_DEPTH` is unused.

## Test plan
- **Clean stream:** 100 valid words with no flags → all counters 0, `cap_valid_o`=0, `irq_o`=0.
- **SB then DB:**
  - SB at addr 0x10 with syndrome 0x05, then DB at 0x20 with syndrome 0x40 → `sb_cnt`=1, `db_cnt`=1, `cap_db_o`=1, `cap_addr_o`=0x20, `irq_o`=1.
  - A later SB does not change the capture.
- **Threshold:** `thr_i`=3, three SB events with `sb_fix_i`=1 → `irq_o` rises after the third edge; `fix_cnt`=3. Setting `thr_i`=0 drops `irq_o` in the same cycle.
- **Saturation and gating:**
  - CNT_W=4, 20 DB events → `db_cnt_o`=15.
  - Events with `clkena_i`=0 or `valid_i`=0 are not counted.
- **Clear collision:**
  - `clr_i` with an SB event in the same cycle → `sb_cnt`=1 and CAP_SB, with the new address.
  - Asserting `rst_ni`=0 mid-stream → all outputs return to reset values asynchronously.
- **FIFO (macro on, depth 4):**
  - 5 events without pops → 4 entries, `fifo_ovf_o`=1.
  - Pops return addresses in arrival order, then `fifo_empty_o`=1.
